// File: rtl/taxi_axis_pkg.sv
// AXI4-Stream shared types and helpers.
// Keep-lane utilities used by stream processing blocks.
package taxi_axis_pkg;

   localparam int KEEP_MAX = 64;
   localparam int LANE_W = $clog2(KEEP_MAX + 1);

   typedef logic [KEEP_MAX-1:0] keep_t;
   typedef logic [LANE_W-1:0] lanes_t;

   function automatic lanes_t keep_popcount(input keep_t keep);
      lanes_t n;
      n = '0;
      for (int i = 0; i < KEEP_MAX; i++)
         n = n + lanes_t'(keep[i]);
      return n;
   endfunction

   // Low-order lane mask with the given number of lanes set
   function automatic keep_t keep_mask(input lanes_t lanes);
      keep_t m;
      m = '0;
      for (int i = 0; i < KEEP_MAX; i++)
         m[i] = lanes_t'(i) < lanes;
      return m;
   endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle.
// Widths and sideband enables travel with the interface instance.
interface taxi_axis_if #(
   parameter int DATA_W  = 8,
   parameter bit KEEP_EN = DATA_W > 8,
   parameter int KEEP_W  = (DATA_W + 7) / 8,
   parameter bit STRB_EN = 0,
   parameter bit LAST_EN = 1,
   parameter bit ID_EN   = 0,
   parameter int ID_W    = 8,
   parameter bit DEST_EN = 0,
   parameter int DEST_W  = 8,
   parameter bit USER_EN = 0,
   parameter int USER_W  = 1
);

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic [KEEP_W-1:0] tstrb;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic [DEST_W-1:0] tdest;
   logic [USER_W-1:0] tuser;

   modport src (
      output tdata, tkeep, tstrb, tvalid,
      output tlast, tid, tdest, tuser,
      input  tready
   );

   modport snk (
      input  tdata, tkeep, tstrb, tvalid,
      input  tlast, tid, tdest, tuser,
      output tready
   );

endinterface

// File: rtl/taxi_axis_frame_trunc.sv
// AXI4-Stream frame length limiter: cuts frames at a runtime byte limit.
// Zero-latency datapath; only control state and status are registered.
module taxi_axis_frame_trunc
   import taxi_axis_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   taxi_axis_if.snk         s_axis,
   taxi_axis_if.src         m_axis,
   input  logic [LEN_W-1:0] cfg_max_len,
   output logic             status_valid,
   output logic [LEN_W-1:0] status_frame_len,
   output logic             status_trunc
);

   localparam int DATA_W  = s_axis.DATA_W;
   localparam int KEEP_W  = s_axis.KEEP_W;
   localparam bit KEEP_EN = s_axis.KEEP_EN;
   localparam bit USER_EN = s_axis.USER_EN;
   localparam int USER_W  = s_axis.USER_W;

   if (m_axis.DATA_W != DATA_W) begin : g_chk_data
      $fatal(0, "DATA_W mismatch (%m)");
   end
   if (m_axis.KEEP_W != KEEP_W) begin : g_chk_keep
      $fatal(0, "KEEP_W mismatch (%m)");
   end
   if (KEEP_W > KEEP_MAX) begin : g_chk_max
      $fatal(0, "KEEP_W too large (%m)");
   end

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t           state_q;
   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] max_q;
   logic             sv_q;
   logic [LEN_W-1:0] len_q;
   logic             st_q;

   logic [LEN_W-1:0] max_len;
   logic [LEN_W:0]   beat_b;
   logic [LEN_W:0]   sum;
   logic [LEN_W-1:0] sum_sat;
   logic [LEN_W-1:0] out_len;
   logic [KEEP_W-1:0] keep_m;
   logic             limited;
   logic             at_max;
   logic             over;
   logic             trunc;
   logic             last_o;
   logic             in_drop;
   logic             xfer;

   // First beat decides against the live config, later beats the latched one
   always_comb begin
      max_len = (state_q == IDLE) ? cfg_max_len : max_q;
      beat_b  = KEEP_EN
         ? (LEN_W+1)'(keep_popcount(keep_t'(s_axis.tkeep)))
         : (LEN_W+1)'(KEEP_W);
      sum     = {1'b0, count_q} + beat_b;
      limited = max_len != '0;
      at_max  = limited && (sum == {1'b0, max_len});
      over    = limited && (sum > {1'b0, max_len});
      trunc   = over || (at_max && !s_axis.tlast);
      last_o  = s_axis.tlast || at_max || over;
      sum_sat = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
      out_len = over ? max_len : sum_sat;
      keep_m  = '1;
      if (over)
         keep_m = KEEP_W'(keep_mask(lanes_t'(max_len - count_q)));
   end

   assign in_drop = state_q == DROP;
   assign xfer    = s_axis.tvalid && s_axis.tready;

   assign s_axis.tready = in_drop || m_axis.tready;
   assign m_axis.tvalid = s_axis.tvalid && !in_drop;
   assign m_axis.tdata  = s_axis.tdata;
   assign m_axis.tkeep  = s_axis.tkeep & keep_m;
   assign m_axis.tstrb  = s_axis.tstrb & keep_m;
   assign m_axis.tlast  = last_o;
   assign m_axis.tid    = s_axis.tid;
   assign m_axis.tdest  = s_axis.tdest;
   assign m_axis.tuser  = s_axis.tuser | USER_W'(USER_EN && trunc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         max_q   <= '0;
         sv_q    <= 1'b0;
         len_q   <= '0;
         st_q    <= 1'b0;
      end else begin
         sv_q <= 1'b0;
         unique case (state_q)
            IDLE, PASS: begin
               if (xfer) begin
                  if (state_q == IDLE)
                     max_q <= cfg_max_len;
                  if (last_o) begin
                     sv_q    <= 1'b1;
                     len_q   <= out_len;
                     st_q    <= trunc;
                     count_q <= '0;
                     state_q <= s_axis.tlast ? IDLE : DROP;
                  end else begin
                     count_q <= sum_sat;
                     state_q <= PASS;
                  end
               end
            end
            DROP: begin
               if (xfer && s_axis.tlast)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign status_valid     = sv_q;
   assign status_frame_len = len_q;
   assign status_trunc     = st_q;

endmodule

// File: tb/tb_taxi_axis_frame_trunc.sv
// Scoreboard bench for taxi_axis_frame_trunc.
// Frame-level reference model feeds queues drained by a monitor.
module tb_taxi_axis_frame_trunc;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic [7:0]  id;
      logic [3:0]  dest;
      int          nb;
   } beat_t;

   typedef struct {
      logic [15:0] len;
      logic        tr;
   } stat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg = '0;
   logic        st_v;
   logic [15:0] st_len;
   logic        st_tr;
   bit          bp_on = 1'b0;

   int compared = 0;
   int mism = 0;

   beat_t frm[$];
   beat_t tmp[$];
   beat_t exp_q[$];
   stat_t stat_q[$];

   always #5 clk = ~clk;

   taxi_axis_if #(
      .DATA_W(64), .KEEP_EN(1), .KEEP_W(8), .STRB_EN(1),
      .ID_EN(1), .ID_W(8), .DEST_EN(1), .DEST_W(4),
      .USER_EN(1), .USER_W(1)
   ) s_if (), m_if ();

   taxi_axis_frame_trunc #(.LEN_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .s_axis(s_if),
      .m_axis(m_if),
      .cfg_max_len(cfg),
      .status_valid(st_v),
      .status_frame_len(st_len),
      .status_trunc(st_tr)
   );

   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   function automatic logic [7:0] lanes(input int k);
      logic [8:0] t;
      t = 9'((1 << k) - 1);
      return t[7:0];
   endfunction

   function automatic void build(input int nbytes);
      beat_t b;
      int    rem;
      logic [7:0] id;
      logic [3:0] dest;
      frm.delete();
      id   = 8'($urandom);
      dest = 4'($urandom);
      rem  = nbytes;
      while (rem > 0) begin
         b.nb   = rem > 8 ? 8 : rem;
         b.keep = lanes(b.nb);
         b.data = {$urandom, $urandom};
         b.last = rem == b.nb;
         b.user = $urandom_range(0, 7) == 0;
         b.id   = id;
         b.dest = dest;
         frm.push_back(b);
         rem -= b.nb;
      end
   endfunction

   // Emit min(total, L) bytes; the beat reaching L ends the frame
   function automatic void model(input int ml);
      int    total;
      int    lim;
      int    c;
      int    k;
      beat_t o;
      stat_t s;
      total = 0;
      foreach (frm[i]) total += frm[i].nb;
      lim = (ml == 0) ? (1 << 30) : ml;
      c = 0;
      foreach (frm[i]) begin
         if (c < lim) begin
            k = (frm[i].nb < lim - c) ? frm[i].nb : lim - c;
            o = frm[i];
            o.keep = lanes(k);
            o.last = frm[i].last || (c + frm[i].nb >= lim);
            o.user = frm[i].user
               || ((c + frm[i].nb >= lim) && total > lim);
            exp_q.push_back(o);
         end
         c += frm[i].nb;
      end
      s.len = 16'((total < lim) ? total : lim);
      s.tr  = total > lim;
      stat_q.push_back(s);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mism++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic drive(input int first, input int lastb, input int mid);
      bit acc;
      int n;
      for (int i = first; i <= lastb; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            s_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_if.tdata  = frm[i].data;
         s_if.tkeep  = frm[i].keep;
         s_if.tstrb  = frm[i].keep;
         s_if.tlast  = frm[i].last;
         s_if.tuser  = frm[i].user;
         s_if.tid    = frm[i].id;
         s_if.tdest  = frm[i].dest;
         s_if.tvalid = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            n++;
         end while (!acc && n < 2000);
         if (!acc) begin
            compared++;
            mism++;
            $display("FAIL accept_timeout: beat %0d not taken", i);
            break;
         end
         if (i == first && mid >= 0)
            cfg = 16'(mid);
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic send(input int n, input int ml, input int mid);
      cfg = 16'(ml);
      build(n);
      model(ml);
      drive(0, frm.size() - 1, mid);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_beats", 64'(exp_q.size()), 64'd0);
      chk("drain_status", 64'(stat_q.size()), 64'd0);
   endtask

   initial begin
      beat_t e;
      stat_t s;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tstrb  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = '0;
      s_if.tid    = '0;
      s_if.tdest  = '0;

      fork
         forever begin
            @(negedge clk);
            if (!rst && m_if.tvalid && m_if.tready) begin
               compared++;
               if (exp_q.size() == 0) begin
                  mism++;
                  $display("FAIL beat: unexpected data=%h last=%b",
                     m_if.tdata, m_if.tlast);
               end else begin
                  e = exp_q.pop_front();
                  if (m_if.tdata !== e.data || m_if.tkeep !== e.keep
                      || m_if.tstrb !== e.keep || m_if.tlast !== e.last
                      || m_if.tuser !== e.user || m_if.tid !== e.id
                      || m_if.tdest !== e.dest) begin
                     mism++;
                     $display({"FAIL beat: got d=%h k=%h s=%h l=%b u=%b",
                        " id=%h de=%h want d=%h k=%h l=%b u=%b id=%h de=%h"},
                        m_if.tdata, m_if.tkeep, m_if.tstrb, m_if.tlast,
                        m_if.tuser, m_if.tid, m_if.tdest, e.data, e.keep,
                        e.last, e.user, e.id, e.dest);
                  end
               end
            end
            if (!rst && st_v) begin
               compared++;
               if (stat_q.size() == 0) begin
                  mism++;
                  $display("FAIL status: unexpected len=%0d tr=%b",
                     st_len, st_tr);
               end else begin
                  s = stat_q.pop_front();
                  if (st_len !== s.len || st_tr !== s.tr) begin
                     mism++;
                     $display("FAIL status: got len=%0d tr=%b want len=%0d tr=%b",
                        st_len, st_tr, s.len, s.tr);
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_status_valid", 64'(st_v), 64'd0);
      chk("rst_status_len", 64'(st_len), 64'd0);
      chk("rst_status_trunc", 64'(st_tr), 64'd0);
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      rst = 1'b0;

      bp_on = 1'b1;
      send(64, 0, -1);
      send(65, 0, -1);
      send(1, 0, -1);
      drain();

      send(64, 60, -1);
      send(40, 16, -1);
      send(8, 16, -1);
      send(16, 16, -1);
      send(24, 100, 8);
      send(24, 8, -1);
      drain();

      cfg = 16'd16;
      build(40);
      model(16);
      drive(0, 2, -1);
      drain();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_status_valid", 64'(st_v), 64'd0);
      chk("mid_rst_status_len", 64'(st_len), 64'd0);
      chk("mid_rst_status_trunc", 64'(st_tr), 64'd0);
      tmp = frm[3:4];
      frm = tmp;
      model(16);
      drive(0, 1, -1);
      drain();

      for (int f = 0; f < 30; f++)
         send($urandom_range(1, 70),
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 80), -1);
      drain();

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
         compared, mism);
      $finish;
   end

endmodule

// File: doc/taxi_axis_frame_trunc.md
Name: taxi_axis_frame_trunc

Overview:
AXI4-Stream frame length limiter. It sits directly upstream of a taxi_axis_register output stage on the switch ingress path. It counts bytes per frame and passes frames up to a runtime maximum unchanged. A frame that exceeds the maximum is cut: the boundary beat gets forced tlast, masked tkeep and an error flag in tuser[0], and the remaining beats are dropped. A per-frame status pulse reports the byte count and whether the frame was truncated.

Parameters:
- LEN_W, 16: width of the byte counter, cfg_max_len and status_frame_len.
- Data, keep, last, id, dest and user widths/enables come from the interfaces.
  - DATA_W and KEEP_W must match between s_axis and m_axis, else $fatal.
  - KEEP_EN=0 means every beat carries KEEP_W bytes.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- s_axis, taxi_axis_if.snk, interface: input stream.
- m_axis, taxi_axis_if.src, interface: output stream.
- cfg_max_len, input, LEN_W: maximum frame length in bytes; 0 = unlimited.
- status_valid, output, 1: one-cycle pulse per completed output frame.
- status_frame_len, output, LEN_W: bytes emitted for that frame.
- status_trunc, output, 1: that frame was truncated.

Behaviour:
- Datapath is combinational (0-cycle latency). Only control and status are registered. Timing closure relies on the downstream register.
- Reset values:
  - state=IDLE, count=0.
  - status_valid=0, status_trunc=0, status_frame_len=0.
  - m_axis.tvalid follows s_axis.tvalid combinationally, so it is 0 when input is idle.
- Beat bytes b = popcount(tkeep) if KEEP_EN, else KEEP_W. tkeep is assumed contiguous from bit 0.
- max_len is latched from cfg_max_len on the first beat of each frame, at the accepted transfer in IDLE. Changes mid-frame take effect on the next frame.
- States:
  - IDLE/PASS (one flag tracks first-beat): m_axis.tvalid=s_axis.tvalid, s_axis.tready=m_axis.tready. Fields pass through.
  - DROP: s_axis.tready=1, m_axis.tvalid=0. Input beats are consumed and discarded.
- Per accepted beat in PASS (handshake on s_axis.tvalid && m_axis.tready):
  - max_len==0 or count+b < max_len: pass unchanged. count += b, saturating at 2^LEN_W-1.
  - count+b == max_len and tlast=1: pass unchanged, normal end.
  - count+b == max_len and tlast=0: pass with tlast forced 1 and tuser[0] set. Frame is truncated; go to DROP.
  - count+b > max_len: remaining r = max_len-count. Output tkeep = ((1<<r)-1) & tkeep, tlast=1, tuser[0]=1. Frame is truncated. Go to DROP if input tlast=0, else to IDLE.
  - The truncation flag is ORed into tuser[0] only if USER_EN. If USER_EN=0 it is reported via status_trunc only.
- Frame end (output tlast beat accepted):
  - Next cycle: status_valid=1, status_frame_len = bytes emitted, status_trunc = flag.
  - Then count=0 and state returns to IDLE or goes to DROP.
- In DROP, when the accepted input beat has tlast=1, go to IDLE the next cycle. There is no second status pulse.
- Dropped beats never produce output. Back-to-back frames need no idle gap. A single-beat frame is its own first and last beat.
- Reset mid-frame: immediately IDLE, and the partial frame status is discarded. The next input beat is treated as a frame start, even if it is a continuation. A downstream consumer sees a runt frame; this is accepted behaviour.
- No bubbles in PASS. Throughput is 1 beat/cycle in both PASS and DROP.
- tid, tdest and tstrb pass unchanged. tstrb is masked the same as tkeep when truncation masks tkeep.

Decomposition:
- The popcount and mask generation are small functions. Put them in the shared taxi_axis_pkg, beside the existing stream helpers.
- No state typedef is needed beyond a local enum {IDLE, PASS, DROP}.
- No sub-module. A wrapper pairing this block with taxi_axis_register (REG_TYPE=2) is left to the integrating top level.

Test Plan:
- Common setup: DATA_W=64, KEEP_W=8, LEN_W=16, USER_W=1.
- cfg_max_len=0, 3 frames of 64/65/1 bytes with random m_axis.tready backpressure -> output bit-identical to input. status_frame_len = 64, 65, 1 with status_trunc=0.
- cfg_max_len=60, 64-byte frame of 8 full beats -> beats 0-6 pass unchanged. Beat 7 gets tkeep=0x0F, tlast=1, tuser=1. status_frame_len=60, status_trunc=1.
- cfg_max_len=16, 40-byte frame -> 2 beats out, beat 1 forced tlast=1, tuser=1. Remaining 3 input beats accepted with m_axis.tvalid=0. The following 8-byte frame passes immediately with status_trunc=0.
- cfg_max_len=16, exact 16-byte frame with tlast on beat 1 -> passes unchanged, status_trunc=0, single status pulse.
- cfg_max_len changed from 100 to 8 mid-frame (frame of 24 bytes) -> the current frame completes untruncated. The next 24-byte frame is truncated to 8 bytes.
- rst asserted for 1 cycle while in DROP -> state IDLE, all status outputs 0. The next beat passes through as a new frame start.
